// File: rtl/hilo_muldiv_unit_if.sv
// Command/result bundle between decode/execute and the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs, rt, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, flush,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: shift-add multiply and restoring
// divide on magnitudes, one iteration per clock, with sign fixup on the final edge.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input logic              clk,
  input logic              reset_n,
  hilo_muldiv_unit_if.slave bus
);
  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_NOP7  = 3'b111
  } op_t;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q, dbz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [2*WIDTH-1:0] acc_q, acc_step, prod_fix;
  logic [WIDTH-1:0]   b_q, q_fix, r_fix, res_hi, res_lo;
  logic               is_div_q, b_zero_q, neg_q, neg_r_q;
  logic [WIDTH:0]     sum, shifted, diff;
  logic               ge;

  logic is_mul_op, is_div_op, is_signed_op;
  logic accept, start_md, finish, busy;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_wide(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign is_mul_op    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign is_div_op    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign is_signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_md) state_d = RUN;
      RUN:     if (bus.flush) state_d = IDLE;
               else if (cnt_q == LAST) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // flush always beats start, including in IDLE and on the FINISH edge
  always_comb begin
    busy     = (state_q != IDLE);
    accept   = bus.start && !bus.flush && (state_q == IDLE);
    start_md = accept && (is_mul_op || is_div_op);
    finish   = (state_q == FINISH) && !bus.flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      if (start_md)              cnt_q <= '0;
      else if (state_q == RUN)   cnt_q <= cnt_q + 1'b1;
      done_q <= finish;
      dbz_q  <= finish && is_div_q && b_zero_q;
    end
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff     = shifted - {1'b0, b_q};
    ge       = (shifted >= {1'b0, b_q});
    if (is_div_q) acc_step = {(ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
    else          acc_step = {sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (start_md) begin
      acc_q    <= {{WIDTH{1'b0}}, (is_signed_op ? mag($signed(bus.rs)) : bus.rs)};
      b_q      <= is_signed_op ? mag($signed(bus.rt)) : bus.rt;
      is_div_q <= is_div_op;
      b_zero_q <= (bus.rt == '0);
      neg_q    <= is_signed_op && (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
      neg_r_q  <= is_signed_op && bus.rs[WIDTH-1];
    end else if (state_q == RUN) begin
      acc_q    <= acc_step;
    end
  end

  // Signed quotient follows operand signs, remainder follows the dividend
  always_comb begin
    prod_fix = neg_wide(acc_q, neg_q);
    q_fix    = neg_word(acc_q[WIDTH-1:0], neg_q);
    r_fix    = neg_word(acc_q[2*WIDTH-1:WIDTH], neg_r_q);
    res_hi   = is_div_q ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = is_div_q ? q_fix : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (accept && (bus.op == OP_MTHI)) hi_q <= bus.rs;
      if (accept && (bus.op == OP_MTLO)) lo_q <= bus.rs;
      if (finish && !(is_div_q && b_zero_q)) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and random bench for hilo_muldiv_unit against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv_unit;
  localparam int W = 32;
  localparam logic [2:0] MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3, DIVU = 3'd4,
                         MTHI = 3'd5, MTLO = 3'd6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   ncmp = 0;
  int   nfail = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus ();

  hilo_muldiv_unit #(.WIDTH(W), .ITER(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint sa, sb, q, r;
    logic [63:0] p;
    eh = mhi; el = mlo; ez = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MULT:  begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      MULTU: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
      DIV, DIVU: begin
        if (b == 32'd0) ez = 1'b1;
        else begin
          if (op == DIV) begin q = sa / sb; r = sa % sb; end
          else begin
            q = longint'({32'b0, a}) / longint'({32'b0, b});
            r = longint'({32'b0, a}) % longint'({32'b0, b});
          end
          el = q[31:0];
          eh = r[31:0];
        end
      end
      MTHI: eh = a;
      MTLO: el = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.rs = a; bus.rt = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd0;
  endtask

  // Issues one command; inj_at/fl_at (>0) drive an MTHI attempt or a flush at that busy cycle
  task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj_at, input int fl_at);
    logic [31:0] eh, el;
    logic ez;
    int n;
    model(op, a, b, eh, el, ez);
    issue(op, a, b);
    if (op == MTHI || op == MTLO) begin
      mhi = eh; mlo = el;
      check("mt_busy", 64'(bus.busy), 64'h0);
      check("mt_done", 64'(bus.done), 64'h0);
      check("mt_hi", 64'(bus.hi), 64'(mhi));
      check("mt_lo", 64'(bus.lo), 64'(mlo));
      return;
    end
    check("md_done_clear", 64'(bus.done), 64'h0);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      check("hold_hi", 64'(bus.hi), 64'(mhi));
      check("hold_lo", 64'(bus.lo), 64'(mlo));
      n++;
      if (n == inj_at) begin bus.start = 1'b1; bus.op = MTHI; bus.rs = 32'h1234; end
      if (n == fl_at) bus.flush = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0;
    end
    if (fl_at > 0) begin
      check("flush_len", 64'(n), 64'(fl_at));
      check("flush_nodone", 64'(bus.done), 64'h0);
      check("flush_hi", 64'(bus.hi), 64'(mhi));
      check("flush_lo", 64'(bus.lo), 64'(mlo));
      @(negedge clk);
      check("flush_nodone2", 64'(bus.done), 64'h0);
    end else begin
      check("busy_len", 64'(n), 64'd33);
      check("done", 64'(bus.done), 64'h1);
      check("dbz", 64'(bus.div_by_zero), 64'(ez));
      mhi = eh; mlo = el;
      check("res_hi", 64'(bus.hi), 64'(mhi));
      check("res_lo", 64'(bus.lo), 64'(mlo));
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0; bus.op = 3'd0; bus.rs = '0; bus.rt = '0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", 64'(bus.hi), 64'h0);
    check("rst_lo", 64'(bus.lo), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
    check("rst_dbz", 64'(bus.div_by_zero), 64'h0);
    reset_n = 1'b1;
    @(negedge clk);

    run_cmd(MULT, 32'hFFFFFFFD, 32'h7, -1, -1);
    check("mult_hi_c", 64'(bus.hi), 64'hFFFFFFFF);
    check("mult_lo_c", 64'(bus.lo), 64'hFFFFFFEB);
    run_cmd(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1);
    check("multu_hi_c", 64'(bus.hi), 64'hFFFFFFFE);
    check("multu_lo_c", 64'(bus.lo), 64'h1);
    run_cmd(DIV, 32'hFFFFFFF9, 32'h2, -1, -1);
    check("div_lo_c", 64'(bus.lo), 64'hFFFFFFFD);
    check("div_hi_c", 64'(bus.hi), 64'hFFFFFFFF);
    run_cmd(DIVU, 32'd100, 32'd7, -1, -1);
    check("divu_lo_c", 64'(bus.lo), 64'd14);
    check("divu_hi_c", 64'(bus.hi), 64'd2);
    run_cmd(DIV, 32'h80000000, 32'hFFFFFFFF, -1, -1);
    check("divovf_lo_c", 64'(bus.lo), 64'h80000000);
    check("divovf_hi_c", 64'(bus.hi), 64'h0);

    run_cmd(MTHI, 32'hAAAA, 32'h0, -1, -1);
    run_cmd(MTLO, 32'h5555, 32'h0, -1, -1);
    run_cmd(DIVU, 32'd9, 32'd0, -1, -1);
    check("dz_dbz_c", 64'(bus.div_by_zero), 64'h1);
    check("dz_hi_c", 64'(bus.hi), 64'hAAAA);
    check("dz_lo_c", 64'(bus.lo), 64'h5555);
    @(negedge clk);
    check("dz_dbz_pulse", 64'(bus.div_by_zero), 64'h0);

    run_cmd(DIV, 32'd1000, 32'd3, 5, -1);
    check("inj_hi_c", 64'(bus.hi), 64'd1);
    check("inj_lo_c", 64'(bus.lo), 64'd333);
    run_cmd(MULT, 32'd5, 32'd6, -1, 12);
    check("flush_hi_c", 64'(bus.hi), 64'd1);

    run_cmd(MTLO, 32'h11, 32'h0, -1, -1);
    run_cmd(MULTU, 32'd3, 32'd4, -1, -1);
    check("b2b_hi_c", 64'(bus.hi), 64'h0);
    check("b2b_lo_c", 64'(bus.lo), 64'hC);

    bus.start = 1'b1; bus.op = MTHI; bus.rs = 32'hDEAD; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("fs_mthi_hi", 64'(bus.hi), 64'(mhi));
    bus.start = 1'b1; bus.op = MULT; bus.rs = 32'd2; bus.rt = 32'd2; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("fs_mult_busy", 64'(bus.busy), 64'h0);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb & 32'hFF;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      run_cmd(rop, ra, rb, -1, -1);
    end

    issue(MULTU, 32'hFFFFFFFF, 32'h12345);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'h0);
    check("mid_rst_hi", 64'(bus.hi), 64'h0);
    check("mid_rst_lo", 64'(bus.lo), 64'h0);
    check("mid_rst_done", 64'(bus.done), 64'h0);
    mhi = '0; mlo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 64'(bus.busy), 64'h0);
    run_cmd(MTLO, 32'h5, 32'h0, -1, -1);
    check("post_rst_lo_c", 64'(bus.lo), 64'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
